hazard_forward_unit: RTL

- Tracks destination-register info for the EX, MEM and WB stages of the 5-stage RISC-V pipeline.
- Produces the 2-bit forwarding selects that drive the EX-stage 3:1 operand muxes (ALU operand A and B).
- Detects load-use hazards, which stall IF/ID and insert a bubble into ID/EX.
- Handles branch-taken flushes and keeps saturating stall/flush event counters for performance debug.

---
 rtl/hazard_forward_unit_pkg.sv | 50 +++++
 rtl/hazard_forward_unit_if.sv | 42 ++++
 rtl/hazard_forward_unit_sat_counter.sv | 19 +
 rtl/hazard_forward_unit.sv | 94 +++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline types and forwarding helpers for the 5-stage RISC-V hazard logic.
package riscv_pipe_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } stage_info_t;

  // Later stages only need to know what they will write back.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } dest_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;
  localparam dest_info_t  DEST_BUBBLE  = '0;

  function automatic dest_info_t to_dest(input stage_info_t s);
    dest_info_t d;
    d.valid    = s.valid;
    d.rd       = s.rd;
    d.regwrite = s.regwrite;
    return d;
  endfunction

  function automatic logic writes_reg(input dest_info_t d, input logic [REG_AW-1:0] src);
    return d.valid && d.regwrite && (d.rd != '0) && (d.rd == src);
  endfunction

  // MEM is the younger producer, so it is checked first.
  function automatic logic [1:0] fwd_decode(input logic [REG_AW-1:0] src,
                                            input dest_info_t        mem,
                                            input dest_info_t        wb);
    if (writes_reg(mem, src)) return FWD_EXMEM;
    if (writes_reg(wb, src))  return FWD_MEMWB;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard inputs and the resulting mux selects / pipeline controls.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_AW = riscv_pipe_pkg::REG_AW,
  parameter int unsigned CNT_W  = 32
);
  import riscv_pipe_pkg::*;

  logic              freeze;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_branch_taken;

  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output freeze, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, pc_write, if_id_write, if_id_flush,
           id_ex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  freeze, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, pc_write, if_id_write, if_id_flush,
           id_ex_bubble, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_forward_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX/MEM/WB destination tracking, operand forwarding, load-use stall and branch flush control.
module hazard_forward_unit #(
  parameter int unsigned REG_AW = riscv_pipe_pkg::REG_AW,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_unit_if.slave  hz
);
  import riscv_pipe_pkg::*;

  stage_info_t       ex_q;
  stage_info_t       ex_d;
  dest_info_t        mem_q;
  dest_info_t        wb_q;
  logic [REG_AW-1:0] ld_rd;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              load_use;
  logic              flush;
  logic              stall_inc;
  logic              flush_inc;

  assign ld_rd   = ex_q.rd;
  assign rs1_hit = hz.id_use_rs1 && (hz.id_rs1 == ld_rd);
  assign rs2_hit = hz.id_use_rs2 && (hz.id_rs2 == ld_rd);

  assign load_use = ex_q.valid && ex_q.memread && (ld_rd != '0) &&
                    hz.id_valid && (rs1_hit || rs2_hit);
  assign flush    = hz.ex_branch_taken;

  // A flush swallows a coincident stall, so only one counter moves.
  assign stall_inc = !hz.freeze && load_use && !flush;
  assign flush_inc = !hz.freeze && flush;

  always_comb begin
    ex_d = STAGE_BUBBLE;
    if (hz.id_valid && !load_use && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = hz.id_rd;
      ex_d.regwrite = hz.id_regwrite;
      ex_d.memread  = hz.id_memread;
      ex_d.rs1      = hz.id_rs1;
      ex_d.rs2      = hz.id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= DEST_BUBBLE;
      wb_q  <= DEST_BUBBLE;
    end else if (!hz.freeze) begin
      ex_q  <= ex_d;
      mem_q <= to_dest(ex_q);
      wb_q  <= mem_q;
    end
  end

  always_comb begin
    hz.fwd_a_sel    = fwd_decode(ex_q.rs1, mem_q, wb_q);
    hz.fwd_b_sel    = fwd_decode(ex_q.rs2, mem_q, wb_q);
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    if (hz.freeze) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
    end else if (flush) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_bubble = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (hz.flush_cnt)
  );

endmodule
